can_frame_sequencer: RTL

- Frame-level controller for the CAN decoder.
- Tracks the position of each sampled, destuffed bit within a standard data/remote frame.
- Drives the field-enable flags consumed by the field checkers (EOF checker, CRC checker, destuffer).
- Collects their error results, sequences the error-flag/delimiter recovery and returns the decoder to bus idle.

---
 rtl/can_frame_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/can_frame_sequencer.sv
`timescale 1ns/1ps
// can_frame_sequencer: tracks destuffed bit position in a CAN data/remote frame,
// drives field-enable flags, collects checker errors and sequences error recovery.
// Optional feature macro CAN_EXT_ID_EN: 29-bit identifiers (SRR/IDE/EXT_ID path).
module can_frame_sequencer #(
  parameter int DATA_MAX_BYTES = 8,
  parameter int ERR_FLAG_BITS  = 6,
  parameter int ERR_DELIM_BITS = 8,
  parameter int IFS_BITS       = 3
) (
  input  logic        SP,
  input  logic        reset,
  input  logic        RX,
  input  logic        Bit_Valid,
  input  logic        Stuff_Error,
  input  logic [1:0]  EOF_Error,
  input  logic        CRC_Error,
  output logic        EOF_Flag,
  output logic        CRC_Flag,
  output logic        Stuff_En,
  output logic [3:0]  Field,
`ifdef CAN_EXT_ID_EN
  output logic [28:0] ID,
`else
  output logic [10:0] ID,
`endif
  output logic        RTR,
  output logic [3:0]  DLC,
  output logic        Frame_Done,
  output logic        Error_Flag,
  output logic [2:0]  Error_Code
);
`ifdef CAN_EXT_ID_EN
  localparam int IDW = 29;
`else
  localparam int IDW = 11;
`endif
  localparam logic [3:0] MAXB = 4'(DATA_MAX_BYTES);

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_STUFF = 3'd1;
  localparam logic [2:0] E_FORM  = 3'd2;
  localparam logic [2:0] E_CRC   = 3'd3;
  localparam logic [2:0] E_ACK   = 3'd4;
  localparam logic [2:0] E_EOF   = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_ID      = 4'd1,
    S_RTR     = 4'd2,
    S_IDE     = 4'd3,
    S_DLC     = 4'd4,
    S_DATA    = 4'd5,
    S_CRC     = 4'd6,
    S_CRC_DEL = 4'd7,
    S_ACK     = 4'd8,
    S_ACK_DEL = 4'd9,
    S_EOF     = 4'd10,
    S_IFS     = 4'd11,
    S_ERROR   = 4'd12,
    S_EXT_ID  = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d, cnt_inc;
  logic [IDW-1:0]   id_q, id_d;
  logic             rtr_q, rtr_d;
  logic [3:0]       dlc_q, dlc_d, dlc_nxt;
  logic             eof_flag_q, eof_flag_d;
  logic             crc_flag_q, crc_flag_d;
  logic             stuff_en_q, stuff_en_d;
  logic             frame_done_q, frame_done_d;
  logic             err_flag_q, err_flag_d;
  logic             err_delim_q, err_delim_d;
  logic [2:0]       err_code_q, err_code_d, err_n;
  logic             ext_q, ext_d;
  logic [7:0]       data_bits;
  logic             eof_err_hi_unused;
`ifdef CAN_EXT_ID_EN
  logic             srr_q, srr_d;
`endif

  assign eof_err_hi_unused = EOF_Error[1];

  function automatic logic [3:0] byte_cnt(input logic [3:0] dlc, input logic rtr);
    if (rtr) return 4'd0;
    return (dlc > MAXB) ? MAXB : dlc;
  endfunction

  always_ff @(posedge SP or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      id_q         <= '0;
      rtr_q        <= 1'b0;
      dlc_q        <= '0;
      eof_flag_q   <= 1'b1;
      crc_flag_q   <= 1'b1;
      stuff_en_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_flag_q   <= 1'b0;
      err_delim_q  <= 1'b0;
      err_code_q   <= E_NONE;
      ext_q        <= 1'b0;
`ifdef CAN_EXT_ID_EN
      srr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      rtr_q        <= rtr_d;
      dlc_q        <= dlc_d;
      eof_flag_q   <= eof_flag_d;
      crc_flag_q   <= crc_flag_d;
      stuff_en_q   <= stuff_en_d;
      frame_done_q <= frame_done_d;
      err_flag_q   <= err_flag_d;
      err_delim_q  <= err_delim_d;
      err_code_q   <= err_code_d;
      ext_q        <= ext_d;
`ifdef CAN_EXT_ID_EN
      srr_q        <= srr_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    rtr_d        = rtr_q;
    dlc_d        = dlc_q;
    eof_flag_d   = eof_flag_q;
    crc_flag_d   = crc_flag_q;
    stuff_en_d   = stuff_en_q;
    frame_done_d = 1'b0;
    err_flag_d   = err_flag_q;
    err_delim_d  = err_delim_q;
    err_code_d   = err_code_q;
    ext_d        = ext_q;
`ifdef CAN_EXT_ID_EN
    srr_d        = srr_q;
`endif
    err_n        = E_NONE;
    cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + 8'd1;
    dlc_nxt      = {dlc_q[2:0], RX};
    data_bits    = {1'b0, byte_cnt(dlc_q, rtr_q), 3'b000};

    case (state_q)
      S_IDLE, S_IFS: begin
        if (!RX) begin
          // Dominant bit while idle or in intermission is a SOF
          state_d    = S_ID;
          cnt_d      = '0;
          id_d       = '0;
          ext_d      = 1'b0;
          stuff_en_d = 1'b1;
          err_code_d = E_NONE;
        end else if (state_q == S_IFS) begin
          cnt_d = cnt_inc;
          if (cnt_q == 8'(IFS_BITS - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      S_ID, S_EXT_ID: if (Bit_Valid) begin
        id_d  = {id_q[IDW-2:0], RX};
        cnt_d = cnt_inc;
        if ((state_q == S_ID && cnt_q == 8'd10) || (state_q == S_EXT_ID && cnt_q == 8'd17)) begin
          state_d = S_RTR;
          cnt_d   = '0;
          if (state_q == S_EXT_ID) ext_d = 1'b1;
        end
      end
      S_RTR: if (Bit_Valid) begin
        rtr_d   = RX;
`ifdef CAN_EXT_ID_EN
        if (!ext_q) srr_d = RX;
`endif
        state_d = S_IDE;
        cnt_d   = '0;
      end
      S_IDE: if (Bit_Valid) begin
        cnt_d = cnt_inc;
        if (cnt_q == 8'd0 && RX && !ext_q) begin
`ifdef CAN_EXT_ID_EN
          if (!srr_q) err_n = E_FORM;
          else begin
            state_d = S_EXT_ID;
            cnt_d   = '0;
          end
`else
          err_n = E_FORM;
`endif
        end else if (cnt_q == 8'd1) begin
          state_d = S_DLC;
          cnt_d   = '0;
        end
      end
      S_DLC: if (Bit_Valid) begin
        dlc_d = dlc_nxt;
        cnt_d = cnt_inc;
        if (cnt_q == 8'd3) begin
          cnt_d = '0;
          if (byte_cnt(dlc_nxt, rtr_q) == 4'd0) begin
            state_d    = S_CRC;
            crc_flag_d = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: if (Bit_Valid) begin
        cnt_d = cnt_inc;
        if (cnt_q == data_bits - 8'd1) begin
          state_d    = S_CRC;
          cnt_d      = '0;
          crc_flag_d = 1'b0;
        end
      end
      S_CRC: if (Bit_Valid) begin
        cnt_d = cnt_inc;
        if (cnt_q == 8'd14) begin
          state_d    = S_CRC_DEL;
          cnt_d      = '0;
          stuff_en_d = 1'b0;
          crc_flag_d = 1'b1;
        end
      end
      S_CRC_DEL: begin
        if (!RX) err_n = E_FORM;
        else if (CRC_Error) err_n = E_CRC;
        else state_d = S_ACK;
      end
      S_ACK: begin
        if (RX) err_n = E_ACK;
        else state_d = S_ACK_DEL;
      end
      S_ACK_DEL: begin
        if (!RX) err_n = E_FORM;
        else begin
          state_d    = S_EOF;
          cnt_d      = '0;
          eof_flag_d = 1'b0;
        end
      end
      S_EOF: begin
        if (!EOF_Error[0]) err_n = E_EOF;
        else begin
          cnt_d = cnt_inc;
          if (cnt_q == 8'd6) begin
            state_d      = S_IFS;
            cnt_d        = '0;
            eof_flag_d   = 1'b1;
            frame_done_d = 1'b1;
          end
        end
      end
      S_ERROR: begin
        if (!err_delim_q) begin
          cnt_d = cnt_inc;
          if (cnt_q == 8'(ERR_FLAG_BITS - 1)) begin
            err_flag_d  = 1'b0;
            err_delim_d = 1'b1;
            cnt_d       = '0;
          end
        end else if (!RX) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q == 8'(ERR_DELIM_BITS - 1)) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            err_delim_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Stuff errors win over anything the field logic found, even on stuff bits
    if (stuff_en_q && Stuff_Error) err_n = E_STUFF;

    if (err_n != E_NONE) begin
      state_d      = S_ERROR;
      cnt_d        = '0;
      err_flag_d   = 1'b1;
      err_delim_d  = 1'b0;
      eof_flag_d   = 1'b1;
      crc_flag_d   = 1'b1;
      stuff_en_d   = 1'b0;
      frame_done_d = 1'b0;
      err_code_d   = err_n;
    end
  end

  assign EOF_Flag   = eof_flag_q;
  assign CRC_Flag   = crc_flag_q;
  assign Stuff_En   = stuff_en_q;
  assign Field      = state_q;
  assign ID         = id_q;
  assign RTR        = rtr_q;
  assign DLC        = dlc_q;
  assign Frame_Done = frame_done_q;
  assign Error_Flag = err_flag_q;
  assign Error_Code = err_code_q;

endmodule
